pc_call_stack: RTL and testbench
================================

Name: pc_call_stack

Overview:
- Parametrised program counter, successor to the plain load/increment PC.
- Adds relative branch, skip-next, and subroutine call/return backed by a DEPTH-entry hardware return-address stack.
- Sits between the instruction decoder (which drives op/EN/data_in) and the program memory address port (data_out).
- Stack overflow and underflow are reported through sticky error flags for the control unit.

Parameters:
- WIDTH, 8: PC and address width in bits.
- DEPTH, 4: return-stack entries; must be 1 or more.
- RESET_VECTOR, 0: PC value after reset (WIDTH bits).

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  synchronous active-low reset (rst==0 at posedge resets).
- WE  input  1  absolute load strobe; loads data_in into the PC, no stack change; takes effect regardless of EN.
- EN  input  1  step enable; op is executed only when EN=1 and WE=0.
- op  input  3  command: 000 INC, 001 JMP, 010 BRA, 011 SKIP, 100 CALL, 101 RET, 110/111 reserved (execute as INC).
- data_in  input  WIDTH  target address (JMP/CALL/WE) or signed offset (BRA).
- clr_err  input  1  clears ovf/unf at posedge.
- data_out  output  WIDTH  current PC (registered).
- top  output  WIDTH  stack entry that RET would pop; 0 when empty.
- depth  output  $clog2(DEPTH+1)  number of valid stack entries.
- full  output  1  depth==DEPTH.
- empty  output  1  depth==0.
- ovf  output  1  sticky: CALL issued while full.
- unf  output  1  sticky: RET issued while empty.

Behaviour:
- Reset (rst==0 at posedge) overrides everything:
  - data_out=RESET_VECTOR, depth=0, empty=1, full=0, ovf=0, unf=0, top=0.
  - Stack contents become don't-care.
- Priority each posedge (rst high): WE > EN/op > hold.
- WE=1: data_out<=data_in. Stack and flags are unchanged, except clr_err, which is still honoured.
- EN=0 and WE=0: all state holds, except that clr_err still acts.
- All PC arithmetic is modulo 2^WIDTH; wrap-around is silent (max+1 -> 0).
- Commands, executed when EN=1 and WE=0:
  - INC: PC<=PC+1.
  - JMP: PC<=data_in.
  - BRA: PC<=PC+data_in, with data_in read as two's-complement signed WIDTH bits. Offset is relative to the current PC, so BRA 0 holds the PC.
  - SKIP: PC<=PC+2.
  - CALL, not full: push PC+1 (mod 2^WIDTH), depth+1, PC<=data_in.
  - CALL, full: PC<=data_in, nothing pushed, stack unchanged, ovf<=1.
  - RET, not empty: PC<=top, pop, depth-1.
  - RET, empty: PC<=PC+1, unf<=1, depth stays 0.
- Stack is LIFO with no wrap. top, full, empty and depth are combinational from registered state, so they are valid in the cycle after the push/pop.
- Latency: one cycle. data_out reflects the command from the posedge it was sampled.
- Flags: ovf/unf are set by the event and cleared only by reset or clr_err.
  - If clr_err and a new error event occur in the same cycle, the set wins (flag=1).
- A reserved op behaves exactly as INC, with no flag set.

Test Plan:
- Reset then 3 cycles EN=1, op=INC -> data_out 0,1,2,3; empty=1, depth=0; rst low mid-run at PC=3 -> next posedge data_out=0.
- WIDTH=8, PC=0xFE, INC x2 -> 0xFF then 0x00. BRA with data_in=0xFB at PC=0x10 -> 0x0B. SKIP at 0x0B -> 0x0D.
- CALL 0x40 at PC=0x05, CALL 0x80 at 0x40 -> PC=0x80, depth=2, top=0x41. RET -> PC=0x41, top=0x06. RET -> PC=0x06, empty=1.
- DEPTH=4: five CALLs from PCs 1,2,3,4,5 -> fifth jumps but ovf=1, depth=4, top=0x05 (from 4th call). Four RETs return 5,4,3,2.
- RET with empty stack at PC=0x20 -> PC=0x21, unf=1. clr_err pulse -> unf=0. clr_err coincident with another empty RET -> unf stays 1.
- EN=0 with WE=1, data_in=0x33, op=CALL -> PC=0x33, depth unchanged. EN=0, WE=0, op=JMP -> PC holds.

Source files
------------

// File: rtl/pc_call_stack_if.sv
// pc_call_stack_if: decoder-side command bus and status of the call-stack program counter
interface pc_call_stack_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int DW = $clog2(DEPTH + 1);
  logic             WE;
  logic             EN;
  logic [2:0]       op;
  logic [WIDTH-1:0] data_in;
  logic             clr_err;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] top;
  logic [DW-1:0]    depth;
  logic             full;
  logic             empty;
  logic             ovf;
  logic             unf;
  modport master (
    output WE, EN, op, data_in, clr_err,
    input  data_out, top, depth, full, empty, ovf, unf
  );
  modport slave (
    input  WE, EN, op, data_in, clr_err,
    output data_out, top, depth, full, empty, ovf, unf
  );
endinterface

// File: rtl/pc_call_stack.sv
// pc_call_stack: program counter with relative branch, skip and a LIFO return-address stack
module pc_call_stack #(
  parameter int               WIDTH        = 8,
  parameter int               DEPTH        = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input logic               clk,
  input logic               rst,
  pc_call_stack_if.slave    bus
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam logic [2:0] OP_JMP = 3'b001, OP_BRA = 3'b010, OP_SKIP = 3'b011,
                         OP_CALL = 3'b100, OP_RET = 3'b101;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d, unf_q, unf_d, push, pop;
  logic [WIDTH-1:0] stk_q [DEPTH];
  logic [WIDTH-1:0] stk_d [DEPTH];
  logic             full, empty, run;
  assign full  = cnt_q == DW'(DEPTH);
  assign empty = cnt_q == '0;
  assign run   = !bus.WE && bus.EN;
  // entry 0 is always the top of stack; push shifts down, pop shifts up
  always_comb begin
    pc_d  = pc_q + 1'b1;
    push  = run && bus.op == OP_CALL && !full;
    pop   = run && bus.op == OP_RET && !empty;
    ovf_d = (ovf_q && !bus.clr_err) || (run && bus.op == OP_CALL && full);
    unf_d = (unf_q && !bus.clr_err) || (run && bus.op == OP_RET && empty);
    cnt_d = push ? cnt_q + 1'b1 : pop ? cnt_q - 1'b1 : cnt_q;
    if (bus.WE) pc_d = bus.data_in;
    else if (!bus.EN) pc_d = pc_q;
    else if (bus.op == OP_JMP || bus.op == OP_CALL) pc_d = bus.data_in;
    else if (bus.op == OP_BRA) pc_d = pc_q + bus.data_in;
    else if (bus.op == OP_SKIP) pc_d = pc_q + WIDTH'(2);
    else if (pop) pc_d = stk_q[0];
    for (int i = 0; i < DEPTH; i++)
      stk_d[i] = push ? (i == 0 ? pc_q + 1'b1 : stk_q[i == 0 ? 0 : i-1])
               : pop  ? (i == DEPTH-1 ? stk_q[i] : stk_q[i == DEPTH-1 ? i : i+1])
               : stk_q[i];
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q  <= RESET_VECTOR;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  always_ff @(posedge clk) stk_q <= stk_d;
  assign bus.data_out = pc_q;
  assign bus.top      = empty ? '0 : stk_q[0];
  assign bus.depth    = cnt_q;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.ovf      = ovf_q;
  assign bus.unf      = unf_q;
endmodule

// File: tb/tb_pc_call_stack.sv
// tb_pc_call_stack: directed vectors with hand-computed expectations for pc_call_stack
module tb_pc_call_stack;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  always #5 clk = ~clk;
  pc_call_stack_if #(.WIDTH(8), .DEPTH(4)) bus ();
  pc_call_stack #(.WIDTH(8), .DEPTH(4), .RESET_VECTOR(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic we, input logic en, input logic [2:0] op,
                       input logic [7:0] d, input logic ce);
    bus.WE = we; bus.EN = en; bus.op = op; bus.data_in = d; bus.clr_err = ce;
    step();
  endtask
  task automatic check_state(input string tag, input logic [7:0] pc, input logic [7:0] top,
                             input logic [2:0] dep, input logic ovf, input logic unf);
    check({tag, ".pc"}, 32'(bus.data_out), 32'(pc));
    check({tag, ".top"}, 32'(bus.top), 32'(top));
    check({tag, ".depth"}, 32'(bus.depth), 32'(dep));
    check({tag, ".full"}, 32'(bus.full), 32'(dep == 3'd4));
    check({tag, ".empty"}, 32'(bus.empty), 32'(dep == 3'd0));
    check({tag, ".ovf"}, 32'(bus.ovf), 32'(ovf));
    check({tag, ".unf"}, 32'(bus.unf), 32'(unf));
  endtask
  initial begin
    rst = 1'b0;
    bus.WE = 0; bus.EN = 0; bus.op = 3'd0; bus.data_in = 8'h00; bus.clr_err = 0;
    step();
    check_state("reset", 8'h00, 8'h00, 3'd0, 0, 0);
    rst = 1'b1;
    drive(0, 1, 3'b000, 8'h00, 0); check_state("inc1", 8'h01, 8'h00, 3'd0, 0, 0);
    drive(0, 1, 3'b000, 8'h00, 0); check("inc2", 32'(bus.data_out), 32'h02);
    drive(0, 1, 3'b000, 8'h00, 0); check("inc3", 32'(bus.data_out), 32'h03);
    rst = 1'b0;
    drive(0, 1, 3'b000, 8'h00, 0); check_state("midreset", 8'h00, 8'h00, 3'd0, 0, 0);
    rst = 1'b1;
    drive(1, 0, 3'b000, 8'hFE, 0); check("load_fe", 32'(bus.data_out), 32'hFE);
    drive(0, 1, 3'b000, 8'h00, 0); check("inc_ff", 32'(bus.data_out), 32'hFF);
    drive(0, 1, 3'b000, 8'h00, 0); check("wrap_00", 32'(bus.data_out), 32'h00);
    drive(1, 1, 3'b000, 8'h10, 0); check("load_10", 32'(bus.data_out), 32'h10);
    drive(0, 1, 3'b010, 8'hFB, 0); check("bra_neg", 32'(bus.data_out), 32'h0B);
    drive(0, 1, 3'b011, 8'h00, 0); check("skip", 32'(bus.data_out), 32'h0D);
    drive(0, 1, 3'b010, 8'h00, 0); check("bra_zero", 32'(bus.data_out), 32'h0D);
    drive(0, 1, 3'b010, 8'h05, 0); check("bra_pos", 32'(bus.data_out), 32'h12);
    drive(0, 1, 3'b001, 8'hA5, 0); check("jmp", 32'(bus.data_out), 32'hA5);
    drive(0, 1, 3'b110, 8'h00, 0); check_state("rsv6", 8'hA6, 8'h00, 3'd0, 0, 0);
    drive(0, 1, 3'b111, 8'h00, 0); check("rsv7", 32'(bus.data_out), 32'hA7);
    // nested call/return
    drive(1, 0, 3'b000, 8'h05, 0);
    drive(0, 1, 3'b100, 8'h40, 0); check_state("call1", 8'h40, 8'h06, 3'd1, 0, 0);
    drive(0, 1, 3'b100, 8'h80, 0); check_state("call2", 8'h80, 8'h41, 3'd2, 0, 0);
    drive(0, 1, 3'b101, 8'h00, 0); check_state("ret1", 8'h41, 8'h06, 3'd1, 0, 0);
    drive(0, 1, 3'b101, 8'h00, 0); check_state("ret2", 8'h06, 8'h00, 3'd0, 0, 0);
    // fill to DEPTH and overflow
    drive(1, 0, 3'b000, 8'h01, 0);
    drive(0, 1, 3'b100, 8'h02, 0); check_state("fill1", 8'h02, 8'h02, 3'd1, 0, 0);
    drive(0, 1, 3'b100, 8'h03, 0); check_state("fill2", 8'h03, 8'h03, 3'd2, 0, 0);
    drive(0, 1, 3'b100, 8'h04, 0); check_state("fill3", 8'h04, 8'h04, 3'd3, 0, 0);
    drive(0, 1, 3'b100, 8'h05, 0); check_state("fill4", 8'h05, 8'h05, 3'd4, 0, 0);
    drive(0, 1, 3'b100, 8'h60, 0); check_state("ovf", 8'h60, 8'h05, 3'd4, 1, 0);
    drive(0, 1, 3'b101, 8'h00, 0); check_state("pop4", 8'h05, 8'h04, 3'd3, 1, 0);
    drive(0, 1, 3'b101, 8'h00, 0); check_state("pop3", 8'h04, 8'h03, 3'd2, 1, 0);
    drive(0, 1, 3'b101, 8'h00, 0); check_state("pop2", 8'h03, 8'h02, 3'd1, 1, 0);
    drive(0, 1, 3'b101, 8'h00, 0); check_state("pop1", 8'h02, 8'h00, 3'd0, 1, 0);
    drive(0, 0, 3'b000, 8'h00, 1); check_state("clr_ovf", 8'h02, 8'h00, 3'd0, 0, 0);
    // underflow and clear interaction
    drive(1, 0, 3'b000, 8'h20, 0);
    drive(0, 1, 3'b101, 8'h00, 0); check_state("unf", 8'h21, 8'h00, 3'd0, 0, 1);
    drive(0, 0, 3'b101, 8'h00, 1); check_state("clr_unf", 8'h21, 8'h00, 3'd0, 0, 0);
    drive(0, 1, 3'b101, 8'h00, 1); check_state("clr_vs_unf", 8'h22, 8'h00, 3'd0, 0, 1);
    // WE priority and hold
    drive(0, 1, 3'b100, 8'h50, 0); check_state("call_hold", 8'h50, 8'h23, 3'd1, 0, 1);
    drive(1, 0, 3'b100, 8'h33, 0); check_state("we_call", 8'h33, 8'h23, 3'd1, 0, 1);
    drive(1, 1, 3'b101, 8'h44, 0); check_state("we_ret", 8'h44, 8'h23, 3'd1, 0, 1);
    drive(0, 0, 3'b001, 8'h77, 0); check_state("hold", 8'h44, 8'h23, 3'd1, 0, 1);
    drive(1, 0, 3'b000, 8'h99, 1); check_state("we_clr", 8'h99, 8'h23, 3'd1, 0, 0);
    // return address wraps modulo 2^WIDTH
    drive(1, 0, 3'b000, 8'hFF, 0);
    drive(0, 1, 3'b100, 8'h10, 0); check_state("call_wrap", 8'h10, 8'h00, 3'd2, 0, 0);
    drive(0, 1, 3'b101, 8'h00, 0); check_state("ret_wrap", 8'h00, 8'h23, 3'd1, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
